local_history_predictor: RTL and testbench



---
 rtl/local_history_predictor.sv | 156 +++++++++++++++
 tb/tb_local_history_predictor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/local_history_predictor.sv
// ---------------------------------------------------------------------------
// local_history_predictor
//
// Local-history stage of the tournament branch predictor. A per-branch local
// history table (LHT), indexed by PC bits, holds a history pattern. That
// pattern indexes a pattern history table (PHT) of saturating counters. The
// counter MSB is the local prediction. Prediction is a 2-stage pipeline, and
// resolved outcomes update both tables. After every reset an init FSM clears
// both tables, and requests are ignored while it runs.
//
// Ports:
//   clock       in   single clock, all logic on posedge
//   reset       in   synchronous active-high; restarts table init
//   pred_req    in   prediction request (sampled every cycle)
//   pred_pc     in   LHT index for pred_req
//   pred_valid  out  one-cycle strobe: prediction / pred_hist are valid
//   prediction  out  1 = taken (PHT counter MSB)
//   pred_hist   out  history used for this prediction (returned on update)
//   upd_valid   in   resolved-branch update strobe
//   upd_pc      in   LHT index of the resolved branch
//   upd_hist    in   pred_hist captured at prediction time
//   upd_taken   in   actual outcome (1 = taken)
//   busy        out  high while the init FSM clears the tables
// ---------------------------------------------------------------------------
module local_history_predictor #(
  parameter int PC_BITS   = 10,
  parameter int HIST_BITS = 10,
  parameter int CTR_BITS  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pred_req,
  input  logic [PC_BITS-1:0]   pred_pc,
  output logic                 pred_valid,
  output logic                 prediction,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 upd_valid,
  input  logic [PC_BITS-1:0]   upd_pc,
  input  logic [HIST_BITS-1:0] upd_hist,
  input  logic                 upd_taken,
  output logic                 busy
);

  // The init sweep covers the larger of the two tables.
  localparam int IDX_BITS = (PC_BITS > HIST_BITS) ? PC_BITS : HIST_BITS;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                init_we;
  logic                run;

  logic [HIST_BITS-1:0] lht_mem [2**PC_BITS];
  logic [CTR_BITS-1:0]  pht_mem [2**HIST_BITS];

  // ---------------- init FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------- init FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ST_INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == '1) state_d = ST_RUN;
    end
  end

  // ---------------- init FSM: outputs ----------------
  // The reset term keeps the cycle in which reset is sampled free of any
  // table write or request acceptance, whatever state the FSM was in.
  always_comb begin
    busy    = (state_q == ST_INIT);
    init_we = (state_q == ST_INIT) && !reset;
    run     = (state_q == ST_RUN) && !reset;
  end

  // ---------------- table update ----------------
  logic                 lht_init_hit, pht_init_hit;
  logic                 upd_en;
  logic [HIST_BITS-1:0] lht_d;
  logic [CTR_BITS-1:0]  ctr_q, ctr_d;

  // When one table is smaller than the sweep, skip out-of-range indices.
  assign lht_init_hit = ((idx_q >> PC_BITS) == '0);
  assign pht_init_hit = ((idx_q >> HIST_BITS) == '0);
  assign upd_en       = upd_valid && run;

  // Read-modify-write against current table contents, so back-to-back
  // updates of the same entry chain through each other's results.
  always_comb begin
    lht_d = {lht_mem[upd_pc][HIST_BITS-2:0], upd_taken};
    ctr_q = pht_mem[upd_hist];
    ctr_d = ctr_q;
    if (upd_taken) begin
      if (ctr_q != '1) ctr_d = ctr_q + 1'b1;
    end else begin
      if (ctr_q != '0) ctr_d = ctr_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (init_we) begin
      if (lht_init_hit) lht_mem[idx_q[PC_BITS-1:0]]   <= '0;
      if (pht_init_hit) pht_mem[idx_q[HIST_BITS-1:0]] <= '0;
    end else if (upd_en) begin
      lht_mem[upd_pc]   <= lht_d;
      pht_mem[upd_hist] <= ctr_d;
    end
  end

  // ---------------- prediction pipeline ----------------
  // Table reads sample the pre-write contents, so a same-cycle update is
  // not bypassed into the read; the update itself still lands.
  logic                 pred_acc;
  logic                 s1_valid_q;
  logic [HIST_BITS-1:0] s1_hist_q;
  logic                 pred_valid_q;
  logic                 prediction_q;
  logic [HIST_BITS-1:0] pred_hist_q;

  assign pred_acc = pred_req && run;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_hist_q    <= '0;
      pred_valid_q <= 1'b0;
      prediction_q <= 1'b0;
      pred_hist_q  <= '0;
    end else begin
      s1_valid_q   <= pred_acc;
      if (pred_acc) s1_hist_q <= lht_mem[pred_pc];
      pred_valid_q <= s1_valid_q;
      // Outputs hold their last values in cycles without a result.
      if (s1_valid_q) begin
        pred_hist_q  <= s1_hist_q;
        prediction_q <= pht_mem[s1_hist_q][CTR_BITS-1];
      end
    end
  end

  assign pred_valid = pred_valid_q;
  assign prediction = prediction_q;
  assign pred_hist  = pred_hist_q;

endmodule

// File: tb/tb_local_history_predictor.sv
// ---------------------------------------------------------------------------
// tb_local_history_predictor
//
// Directed bench for local_history_predictor at PC_BITS=4, HIST_BITS=4,
// CTR_BITS=3. Inputs change 1 time unit after the rising edge and outputs
// are sampled at that same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_local_history_predictor;

  localparam int PB = 4;
  localparam int HB = 4;
  localparam int CB = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          pred_req;
  logic [PB-1:0] pred_pc;
  logic          pred_valid;
  logic          prediction;
  logic [HB-1:0] pred_hist;
  logic          upd_valid;
  logic [PB-1:0] upd_pc;
  logic [HB-1:0] upd_hist;
  logic          upd_taken;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  local_history_predictor #(
    .PC_BITS  (PB),
    .HIST_BITS(HB),
    .CTR_BITS (CB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pred_req  (pred_req),
    .pred_pc   (pred_pc),
    .pred_valid(pred_valid),
    .prediction(prediction),
    .pred_hist (pred_hist),
    .upd_valid (upd_valid),
    .upd_pc    (upd_pc),
    .upd_hist  (upd_hist),
    .upd_taken (upd_taken),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One update per call; upd_valid stays high so calls chain back-to-back.
  task automatic do_upd(input logic [PB-1:0] pc, input logic [HB-1:0] h, input logic t);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_hist  = h;
    upd_taken = t;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic pred_one(input string tag, input logic [PB-1:0] pc,
                          input logic exp_p, input logic [HB-1:0] exp_h);
    pred_req = 1'b1;
    pred_pc  = pc;
    tick();
    pred_req = 1'b0;
    check({tag, "_s1_valid"}, pred_valid, 0);
    tick();
    check({tag, "_valid"}, pred_valid, 1);
    check({tag, "_pred"},  prediction, exp_p);
    check({tag, "_hist"},  pred_hist,  exp_h);
  endtask

  // Counts busy cycles from reset release (the caller releases reset and
  // calls this immediately); pred_valid must never strobe meanwhile.
  task automatic count_busy(input string tag, input logic req_during);
    int cnt;
    int pv;
    cnt = 0;
    pv  = 0;
    pred_req = req_during;
    pred_pc  = 4'd2;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      cnt++;
      if (pred_valid) pv++;
      tick();
    end
    pred_req = 1'b0;
    check({tag, "_busy_cycles"}, cnt, 16);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_pv_during_busy"}, pv, 0);
    tick();
    check({tag, "_pv_after1"}, pred_valid, 0);
    tick();
    check({tag, "_pv_after2"}, pred_valid, 0);
  endtask

  initial begin
    reset     = 1'b1;
    pred_req  = 1'b0;
    pred_pc   = '0;
    upd_valid = 1'b0;
    upd_pc    = '0;
    upd_hist  = '0;
    upd_taken = 1'b0;

    // 1. reset state and init timing, with requests held during busy
    tick();
    tick();
    check("rst_pred_valid", pred_valid, 0);
    check("rst_prediction", prediction, 0);
    check("rst_pred_hist",  pred_hist,  0);
    check("rst_busy",       busy,       1);
    reset = 1'b0;
    count_busy("init", 1'b1);

    // 2. basic predict, then three back-to-back requests
    pred_one("basic_pc5", 4'd5, 1'b0, 4'h0);
    pred_req = 1'b1; pred_pc = 4'd1; tick();
    check("b2b_t1_valid", pred_valid, 0);
    pred_pc = 4'd2; tick();
    check("b2b_r1_valid", pred_valid, 1);
    pred_pc = 4'd3; tick();
    pred_req = 1'b0;
    check("b2b_r2_valid", pred_valid, 1);
    tick();
    check("b2b_r3_valid", pred_valid, 1);
    check("b2b_r3_hist",  pred_hist,  0);
    tick();
    check("b2b_idle_valid", pred_valid, 0);

    // 3. history build: LHT[9]=0011, PHT[F]=2; LHT[1]=1111, PHT[3]=4
    do_upd(4'd9, 4'hF, 1'b0);
    do_upd(4'd9, 4'hF, 1'b0);
    do_upd(4'd9, 4'hF, 1'b1);
    do_upd(4'd9, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) do_upd(4'd1, 4'h3, 1'b1);
    pred_one("hist_pc9", 4'd9, 1'b1, 4'h3);
    pred_one("hist_pc1", 4'd1, 1'b0, 4'hF);

    // 4. saturation on PHT[7]; LHT[13] built to 0111 via PHT[A] (ends at 3)
    do_upd(4'd13, 4'hA, 1'b0);
    for (int i = 0; i < 3; i++) do_upd(4'd13, 4'hA, 1'b1);
    for (int i = 0; i < 9; i++) do_upd(4'd12, 4'h7, 1'b1);
    pred_one("sat_hi7", 4'd13, 1'b1, 4'h7);
    do_upd(4'd12, 4'h7, 1'b0);
    pred_one("sat_hi6", 4'd13, 1'b1, 4'h7);
    for (int i = 0; i < 10; i++) do_upd(4'd12, 4'h7, 1'b0);
    pred_one("sat_lo0", 4'd13, 1'b0, 4'h7);
    pred_one("lht_pc12", 4'd12, 1'b0, 4'h0);

    // 5. same-cycle update and predict of pc 5 (PHT[A] 3->4)
    upd_valid = 1'b1; upd_pc = 4'd5; upd_hist = 4'hA; upd_taken = 1'b1;
    pred_req  = 1'b1; pred_pc = 4'd5;
    tick();
    upd_valid = 1'b0;
    tick();
    pred_req = 1'b0;
    check("coll_r1_valid", pred_valid, 1);
    check("coll_r1_hist",  pred_hist,  4'h0);
    tick();
    check("coll_r2_valid", pred_valid, 1);
    check("coll_r2_hist",  pred_hist,  4'h1);
    check("coll_r2_pred",  prediction, 1'b0);
    pred_one("coll_histA", 4'd13, 1'b0, 4'h7);

    // 6. reset mid-stream discards the in-flight request
    pred_req = 1'b1; pred_pc = 4'd9;
    tick();
    pred_req = 1'b0; reset = 1'b1;
    tick();
    check("mid_rst_pv",   pred_valid, 0);
    check("mid_rst_busy", busy,       1);
    check("mid_rst_hist", pred_hist,  0);
    reset = 1'b0;
    count_busy("reinit", 1'b0);
    pred_one("post_pc9", 4'd9, 1'b0, 4'h0);
    pred_one("post_pc1", 4'd1, 1'b0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
